// File: rtl/display_pkg.sv
// Shared constants and width helper for the seven-segment display path.
package display_pkg;
   localparam int NIBBLE_W       = 4;
   localparam int DEF_NUM_DIGITS = 4;
   localparam int DEF_SCAN_DIV   = 50000;

   // ceil(log2(n)), never less than 1 so single-value counters still get a bit
   function automatic int clog2_min1(input int n);
      int w;
      w = 0;
      while ((1 << w) < n) w++;
      return (w < 1) ? 1 : w;
   endfunction
endpackage

// File: rtl/scan_tick_gen.sv
// Per-digit dwell counter; wrap pulses on the last cycle of every scan slot.
module scan_tick_gen
   import display_pkg::*;
#(
   parameter int SCAN_DIV = DEF_SCAN_DIV
) (
   input  logic clk,
   input  logic rst_n,
   output logic wrap
);
   localparam int CW = clog2_min1(SCAN_DIV);

   logic [CW-1:0] div_cnt;

   // widen both sides so SCAN_DIV-1 is never truncated to CW bits
   assign wrap = (32'(div_cnt) == 32'(SCAN_DIV - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    div_cnt <= '0;
      else if (wrap) div_cnt <= '0;
      else           div_cnt <= div_cnt + CW'(1);
   end
endmodule

// File: rtl/digit_scan_mux.sv
// Multiplexes a NUM_DIGITS hex value onto one seven-segment decoder, swapping
// in newly accepted values only at frame boundaries.
module digit_scan_mux
   import display_pkg::*;
#(
   parameter int NUM_DIGITS    = DEF_NUM_DIGITS,
   parameter int SCAN_DIV      = DEF_SCAN_DIV,
   parameter bit BLANK_LEADING = 1'b1
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           value_valid,
   input  logic [NIBBLE_W*NUM_DIGITS-1:0] value_in,
   output logic                           value_ready,
   output logic [NIBBLE_W-1:0]            nibble,
   output logic [NUM_DIGITS-1:0]          digit_en_n,
   output logic                           frame_tick
);
   localparam int IW = clog2_min1(NUM_DIGITS);
   localparam logic [IW-1:0] LAST_DIG = IW'(NUM_DIGITS - 1);

   typedef logic [NUM_DIGITS-1:0][NIBBLE_W-1:0] digits_t;

   digits_t                active, shadow;
   logic                   pending;
   logic [IW-1:0]          digit_idx;
   logic                   slot_wrap, xfer, blank;
   logic [NUM_DIGITS-1:0]  upper_zero;

   scan_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick (
      .clk   (clk),
      .rst_n (rst_n),
      .wrap  (slot_wrap)
   );

   assign frame_tick  = slot_wrap && (digit_idx == LAST_DIG);
   assign value_ready = !pending;
   assign xfer        = value_valid && !pending;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         digit_idx <= '0;
      else if (slot_wrap)
         digit_idx <= (digit_idx == LAST_DIG) ? '0 : digit_idx + IW'(1);
   end

   // A boundary with pending set cannot also transfer (ready is low), so
   // the swap and a new capture never collide on the same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         active  <= '0;
         shadow  <= '0;
         pending <= 1'b0;
      end else begin
         if (xfer) begin
            shadow  <= value_in;
            pending <= 1'b1;
         end else if (frame_tick && pending) begin
            active  <= shadow;
            pending <= 1'b0;
         end
      end
   end

   for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_zero
      assign upper_zero[i] = (active[NUM_DIGITS-1:i] == '0);
   end

   assign blank      = BLANK_LEADING && (digit_idx != '0) && upper_zero[digit_idx];
   assign nibble     = active[digit_idx];
   assign digit_en_n = blank ? '1 : ~(NUM_DIGITS'(1) << digit_idx);
endmodule

// File: tb/tb_digit_scan_mux.sv
// Scoreboarded bench: accepted values queue up and are retired at frame ends.
module tb_digit_scan_mux;
   localparam int ND = 4;
   localparam int SD = 4;
   localparam int FR = ND * SD;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        value_valid = 1'b0;
   logic [15:0] value_in = '0;
   logic        value_ready, frame_tick, rdy_nb, tick_nb;
   logic [3:0]  nibble, digit_en_n, nib_nb, en_nb;

   always #5 clk = ~clk;

   digit_scan_mux #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BLANK_LEADING(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .value_valid(value_valid), .value_in(value_in),
      .value_ready(value_ready), .nibble(nibble), .digit_en_n(digit_en_n),
      .frame_tick(frame_tick)
   );

   digit_scan_mux #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BLANK_LEADING(1'b0)) dut_nb (
      .clk(clk), .rst_n(rst_n), .value_valid(value_valid), .value_in(value_in),
      .value_ready(rdy_nb), .nibble(nib_nb), .digit_en_n(en_nb),
      .frame_tick(tick_nb)
   );

   int          n_chk = 0;
   int          n_pass = 0;
   int          k = 0;
   logic [15:0] cur = '0;
   logic [15:0] exp_q[$];
   bit          accepted = 1'b0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] want);
      n_chk++;
      if (act === want) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (k=%0d)", tag, act, want, k);
   endtask

   function automatic logic [3:0] exp_en(input logic [15:0] v, input int idx, input bit blank);
      logic [15:0] up;
      logic [3:0]  one;
      up  = v >> (4 * idx);
      one = 4'b0001;
      if (blank && idx > 0 && up == 16'h0) return 4'hF;
      return ~(one << idx);
   endfunction

   // Sample at negedge, then advance the model by the edge about to happen.
   task automatic tick();
      int          idx;
      logic [3:0]  want_nib;
      logic        want_tick, want_rdy;
      @(negedge clk);
      idx       = (k / SD) % ND;
      want_nib  = 4'((cur >> (4 * idx)) & 16'hF);
      want_tick = ((k % FR) == FR - 1);
      want_rdy  = (exp_q.size() == 0);
      chk("frame_tick",    32'(frame_tick), 32'(want_tick));
      chk("frame_tick_nb", 32'(tick_nb),    32'(want_tick));
      chk("value_ready",   32'(value_ready), 32'(want_rdy));
      chk("value_ready_nb", 32'(rdy_nb),    32'(want_rdy));
      chk("nibble",        32'(nibble),     32'(want_nib));
      chk("nibble_nb",     32'(nib_nb),     32'(want_nib));
      chk("digit_en_n",    32'(digit_en_n), 32'(exp_en(cur, idx, 1'b1)));
      chk("digit_en_n_nb", 32'(en_nb),      32'(exp_en(cur, idx, 1'b0)));
      accepted = value_valid && want_rdy;
      if (want_tick && exp_q.size() > 0) cur = exp_q.pop_front();
      if (accepted) exp_q.push_back(value_in);
      k++;
      @(posedge clk);
      #1;
   endtask

   task automatic run(input int n);
      repeat (n) tick();
   endtask

   task automatic run_to(input int phase);
      int guard;
      guard = 0;
      while ((k % FR) != phase && guard < 2 * FR) begin
         tick();
         guard++;
      end
   endtask

   // Holds valid until the model says the block took it.
   task automatic load(input logic [15:0] v);
      int guard;
      value_in    = v;
      value_valid = 1'b1;
      guard       = 0;
      do begin
         tick();
         guard++;
      end while (!accepted && guard < 100);
      chk("load_accept", 32'(accepted), 32'd1);
      value_valid = 1'b0;
   endtask

   task automatic reset_chk(input string tag);
      chk({tag, "_ready"},  32'(value_ready), 32'd1);
      chk({tag, "_nibble"}, 32'(nibble),      32'd0);
      chk({tag, "_en"},     32'(digit_en_n),  32'hE);
      chk({tag, "_en_nb"},  32'(en_nb),       32'hE);
      chk({tag, "_tick"},   32'(frame_tick),  32'd0);
   endtask

   initial begin
      #12;
      reset_chk("rst");
      @(posedge clk);
      #2 rst_n = 1'b1;
      k = 0;

      run(FR);                    // idle frame: only digit 0 ever enabled

      run_to(6);
      load(16'h1A2F);
      run(2 * FR + 4);

      load(16'h0003);             // backpressure: 0004 waits for the swap
      load(16'h0004);
      run(2 * FR + 4);

      load(16'h0050);
      run(2 * FR + 4);

      run_to(FR - 1);             // transfer on a boundary edge waits a frame
      load(16'h00B0);
      run(2 * FR + 4);

      run_to(2);
      load(16'h1234);
      run_to(9);
      #2 rst_n = 1'b0;
      #1 reset_chk("midrst");
      exp_q.delete();
      cur = '0;
      @(posedge clk);
      #2 rst_n = 1'b1;
      k = 0;
      run(2 * FR + 4);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
